alu_sequencer: RTL and testbench

- Command-driven front end for the registered 8-bit ALU. It drives the ALU's opcode and a/b inputs and consumes its out and zero results.
- Accepts one command at a time over a valid/ready handshake and reads operands from an internal 4 x 8-bit register file.
- Waits out the ALU latency, captures the result, writes it back, and returns it over a valid/ready response channel.
- Sits between a test/program driver and the alu instance.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_regfile.sv | 48 ++++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcode and state encodings, the command
// bundle and the data width.
package alu_seq_pkg;

   localparam int DATA_W    = 8;
   localparam int REG_IDX_W = 2;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_OR  = 3'b011,
      OP_SHR = 3'b100,
      OP_XOR = 3'b101,
      OP_SHL = 3'b110,
      OP_AND = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } seq_state_t;

   typedef struct packed {
      alu_op_t               op;
      logic [REG_IDX_W-1:0]  dst;
      logic [REG_IDX_W-1:0]  srca;
      logic [REG_IDX_W-1:0]  srcb;
      logic                  imm_en;
      logic [DATA_W-1:0]     imm;
   } cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer.
//   clk, rst            : clock, async active-high reset (all entries clear to 0)
//   rd_a_*, rd_b_*      : combinational operand read ports
//   dbg_idx / dbg_data  : combinational debug read port
//   wr_en/wr_idx/wr_data: synchronous write port
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int NREGS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_IDX_W-1:0]  rd_a_idx,
   output logic [DATA_W-1:0]     rd_a_data,
   input  logic [REG_IDX_W-1:0]  rd_b_idx,
   output logic [DATA_W-1:0]     rd_b_data,
   input  logic [REG_IDX_W-1:0]  dbg_idx,
   output logic [DATA_W-1:0]     dbg_data,
   input  logic                  wr_en,
   input  logic [REG_IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0]     wr_data
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_a_data = mem_q[rd_a_idx];
   assign rd_b_data = mem_q[rd_b_idx];
   assign dbg_data  = mem_q[dbg_idx];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven front end for a registered 8-bit ALU.
//   cmd_*      : valid/ready command channel (opcode, dst, srca, srcb, immediate)
//   alu_*      : registered opcode/operands to the ALU, its out/zero results back
//   rsp_*      : valid/ready response channel carrying the captured result
//   dbg_sel/dbg_data : combinational register-file peek
//
// state | meaning
// IDLE  | ready for a command; operands are captured on accept
// EXEC  | waiting out ALU_LAT edges, then capture result and write back
// RESP  | response held on rsp_* until rsp_ready
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int NREGS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [REG_IDX_W-1:0]  cmd_dst,
   input  logic [REG_IDX_W-1:0]  cmd_srca,
   input  logic [REG_IDX_W-1:0]  cmd_srcb,
   input  logic                  cmd_imm_en,
   input  logic [DATA_W-1:0]     cmd_imm,
   output logic [2:0]            alu_opcode,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   input  logic [DATA_W-1:0]     alu_out,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_zero,
   input  logic [REG_IDX_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0]     dbg_data
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

   seq_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   alu_op_t               op_q, op_d;
   logic [DATA_W-1:0]     a_q, a_d;
   logic [DATA_W-1:0]     b_q, b_d;
   logic [REG_IDX_W-1:0]  dst_q, dst_d;
   logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
   logic                  rsp_zero_q, rsp_zero_d;

   logic                  ready_c;
   logic                  wr_en;
   logic [DATA_W-1:0]     rd_a_data, rd_b_data;
   cmd_t                  cmd;

   assign cmd = '{op: alu_op_t'(cmd_op), dst: cmd_dst, srca: cmd_srca,
                  srcb: cmd_srcb, imm_en: cmd_imm_en, imm: cmd_imm};

   alu_seq_regfile #(.NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_a_idx  (cmd.srca),
      .rd_a_data (rd_a_data),
      .rd_b_idx  (cmd.srcb),
      .rd_b_data (rd_b_data),
      .dbg_idx   (dbg_sel),
      .dbg_data  (dbg_data),
      .wr_en     (wr_en),
      .wr_idx    (dst_q),
      .wr_data   (alu_out)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      dst_d      = dst_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      ready_c    = 1'b0;
      rsp_valid  = 1'b0;
      wr_en      = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd.op;
               a_d     = rd_a_data;
               b_d     = cmd.imm_en ? cmd.imm : rd_b_data;
               dst_d   = cmd.dst;
               cnt_d   = CNT_W'(ALU_LAT);
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_data_d = alu_out;
               rsp_zero_d = alu_zero;
               wr_en      = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         dst_q      <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         dst_q      <= dst_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
      end
   end

   // state_q sits at IDLE during reset, so ready must be masked explicitly
   assign cmd_ready  = ready_c & ~rst;
   assign alu_opcode = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: instance 0 runs with a 1-deep ALU model, instance 1 with a 3-deep one.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [2:0] cmd_op    [2];
   logic [1:0] cmd_dst   [2];
   logic [1:0] cmd_srca  [2];
   logic [1:0] cmd_srcb  [2];
   logic       cmd_imm_en[2];
   logic [7:0] cmd_imm   [2];
   logic [2:0] alu_opcode[2];
   logic [7:0] alu_a     [2];
   logic [7:0] alu_b     [2];
   logic [7:0] alu_out   [2];
   logic       alu_zero  [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [7:0] rsp_data  [2];
   logic       rsp_zero  [2];
   logic [1:0] dbg_sel   [2];
   logic [7:0] dbg_data  [2];

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] sbq [$];
   logic [7:0] mregs [2][4];

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return 8'((16'(a) * 16'(b)));
         3'b011:  return a | b;
         3'b100:  return a >> b[2:0];
         3'b101:  return a ^ b;
         3'b110:  return a << b[2:0];
         default: return a & b;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_alu
      localparam int L = (g == 0) ? 1 : 3;
      logic [7:0] pipe [L];
      always @(posedge clk) begin
         pipe[0] <= alu_f(alu_opcode[g], alu_a[g], alu_b[g]);
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign alu_out[g]  = pipe[L-1];
      assign alu_zero[g] = (pipe[L-1] == 8'h00);
   end

   alu_sequencer #(.ALU_LAT(1), .NREGS(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
      .cmd_dst(cmd_dst[0]), .cmd_srca(cmd_srca[0]), .cmd_srcb(cmd_srcb[0]),
      .cmd_imm_en(cmd_imm_en[0]), .cmd_imm(cmd_imm[0]),
      .alu_opcode(alu_opcode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
      .alu_out(alu_out[0]), .alu_zero(alu_zero[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_zero(rsp_zero[0]),
      .dbg_sel(dbg_sel[0]), .dbg_data(dbg_data[0])
   );

   alu_sequencer #(.ALU_LAT(3), .NREGS(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
      .cmd_dst(cmd_dst[1]), .cmd_srca(cmd_srca[1]), .cmd_srcb(cmd_srcb[1]),
      .cmd_imm_en(cmd_imm_en[1]), .cmd_imm(cmd_imm[1]),
      .alu_opcode(alu_opcode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
      .alu_out(alu_out[1]), .alu_zero(alu_zero[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_zero(rsp_zero[1]),
      .dbg_sel(dbg_sel[1]), .dbg_data(dbg_data[1])
   );

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Issue one command, check latency, operand stability, result and write-back.
   task automatic send(int k, logic [2:0] op, logic [1:0] dst, logic [1:0] sa,
                       logic [1:0] sb, logic ie, logic [7:0] imm, int hold);
      logic [7:0] ea, eb, ed;
      logic [8:0] exp;
      int lat, waitc;
      int exp_lat = (k == 0) ? 2 : 4;
      ea = mregs[k][sa];
      eb = ie ? imm : mregs[k][sb];
      ed = alu_f(op, ea, eb);
      sbq.push_back({(ed == 8'h00), ed});
      @(negedge clk);
      cmd_op[k] = op; cmd_dst[k] = dst; cmd_srca[k] = sa; cmd_srcb[k] = sb;
      cmd_imm_en[k] = ie; cmd_imm[k] = imm; cmd_valid[k] = 1'b1;
      waitc = 0;
      while (!cmd_ready[k] && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!cmd_ready[k]) begin
         check_val("cmd_ready_timeout", 32'(cmd_ready[k]), 1);
         cmd_valid[k] = 1'b0;
         void'(sbq.pop_front());
         return;
      end
      @(posedge clk); #1;
      cmd_valid[k] = 1'b0;
      lat = 0;
      do begin
         check_val("exec_cmd_ready", 32'(cmd_ready[k]), 0);
         check_val("exec_alu_a", 32'(alu_a[k]), 32'(ea));
         check_val("exec_alu_b", 32'(alu_b[k]), 32'(eb));
         check_val("exec_alu_op", 32'(alu_opcode[k]), 32'(op));
         @(posedge clk); #1;
         lat++;
      end while (!rsp_valid[k] && lat < 20);
      check_val("rsp_latency", lat, exp_lat);
      exp = sbq.pop_front();
      check_val("rsp_data", 32'(rsp_data[k]), 32'(exp[7:0]));
      check_val("rsp_zero", 32'(rsp_zero[k]), 32'(exp[8]));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_val("hold_valid", 32'(rsp_valid[k]), 1);
         check_val("hold_data", 32'(rsp_data[k]), 32'(exp[7:0]));
         check_val("hold_cmd_ready", 32'(cmd_ready[k]), 0);
      end
      mregs[k][dst] = exp[7:0];
      dbg_sel[k] = dst; #1;
      check_val("dbg_wb", 32'(dbg_data[k]), 32'(exp[7:0]));
      @(negedge clk);
      rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[k] = 1'b0;
      check_val("post_rsp_valid", 32'(rsp_valid[k]), 0);
      check_val("post_cmd_ready", 32'(cmd_ready[k]), 1);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         cmd_valid[k] = 0; cmd_op[k] = 0; cmd_dst[k] = 0; cmd_srca[k] = 0;
         cmd_srcb[k] = 0; cmd_imm_en[k] = 0; cmd_imm[k] = 0;
         rsp_ready[k] = 0; dbg_sel[k] = 0;
         for (int r = 0; r < 4; r++) mregs[k][r] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check_val("rst_cmd_ready", 32'(cmd_ready[0]), 0);
      check_val("rst_rsp_valid", 32'(rsp_valid[0]), 0);
      check_val("rst_alu_a", 32'(alu_a[0]), 0);
      check_val("rst_alu_b", 32'(alu_b[0]), 0);
      check_val("rst_alu_op", 32'(alu_opcode[0]), 0);
      check_val("rst_rsp_data", 32'(rsp_data[0]), 0);
      check_val("rst_rsp_zero", 32'(rsp_zero[0]), 0);
      rst = 1'b0;
      #1;
      check_val("rel_cmd_ready", 32'(cmd_ready[0]), 1);

      send(0, 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0);
      send(0, 3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 8'h02, 0);
      send(0, 3'b010, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 0);
      send(0, 3'b001, 2'd0, 2'd2, 2'd2, 1'b0, 8'h00, 0);
      send(0, 3'b011, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 5);
      send(0, 3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 0);
      send(0, 3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFF, 0);
      send(0, 3'b110, 2'd3, 2'd3, 2'd0, 1'b1, 8'h02, 0);

      // Reset while a command is in EXEC
      @(negedge clk);
      cmd_op[0] = 3'b000; cmd_dst[0] = 2'd1; cmd_srca[0] = 2'd0;
      cmd_imm_en[0] = 1'b1; cmd_imm[0] = 8'hFF; cmd_valid[0] = 1'b1;
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      check_val("mid_exec_ready", 32'(cmd_ready[0]), 0);
      rst = 1'b1; #1;
      check_val("mid_rst_ready", 32'(cmd_ready[0]), 0);
      check_val("mid_rst_valid", 32'(rsp_valid[0]), 0);
      repeat (2) @(negedge clk);
      check_val("mid_rst_ready2", 32'(cmd_ready[0]), 0);
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         mregs[0][r] = 8'h00;
         mregs[1][r] = 8'h00;
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check_val("abort_rsp_valid", 32'(rsp_valid[0]), 0);
         check_val("abort_cmd_ready", 32'(cmd_ready[0]), 1);
      end
      for (int r = 0; r < 4; r++) begin
         dbg_sel[0] = 2'(r); #1;
         check_val("abort_reg", 32'(dbg_data[0]), 0);
      end

      send(1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, 0);
      send(1, 3'b101, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F, 2);
      send(1, 3'b111, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
